// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  // One-bit FSM encoding. Plain constants keep the encoding fixed.
  typedef logic [0:0] state_t;
  localparam state_t IDLE         = 1'b0;
  localparam state_t TRANSMITTING = 1'b1;

  // 50 MHz clock / 19200 baud.
  localparam int BAUD_DIV_DEFAULT = 2604;

  // 8N1: start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  // Frame as it is shifted out LSB first: start(0), data LSB..MSB, stop(1).
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the transmitter. A push while full is dropped even if
// a pop happens on the same edge; a pop while empty is ignored.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  // DEPTH is a power of 2, so PW-bit pointers wrap modulo DEPTH for free.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the occupancy state does.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy count; push+pop together leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input queue. Frames run back to back
// while the queue has data; tx_done flags that everything accepted is out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       full
);

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT    = 4'(FRAME_BITS - 1);

  state_t      state, state_nxt;
  logic [9:0]  shreg, shreg_nxt;
  logic [11:0] baud_cnt, baud_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        baud_tick, frame_end, load, push_ok;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (trmt),
    .pop   (load),
    .din   (tx_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (full)
  );

  assign push_ok   = trmt & ~full;
  assign baud_tick = (baud_cnt == '0);
  // Stop bit has just completed its full bit period.
  assign frame_end = (state == TRANSMITTING) && baud_tick && (bit_cnt == LAST_BIT);
  // Start a frame from idle, or chain straight into the next one at frame end.
  assign load      = ~fifo_empty && ((state == IDLE) || frame_end);

  // Next-state for the FSM, bit timing and shift register.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    if (state == TRANSMITTING) begin
      if (baud_tick) begin
        shreg_nxt = {1'b1, shreg[9:1]};
        baud_nxt  = BAUD_RELOAD;
        bit_nxt   = bit_cnt + 4'd1;
      end else begin
        baud_nxt  = baud_cnt - 12'd1;
      end
    end
    if (frame_end) state_nxt = IDLE;
    if (load) begin
      state_nxt = TRANSMITTING;
      shreg_nxt = frame_of(fifo_dout);
      baud_nxt  = BAUD_RELOAD;
      bit_nxt   = '0;
    end
  end

  // Control state and registered outputs; TX tracks the shifter LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      TX      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state <= state_nxt;
      TX    <= (state_nxt == IDLE) ? 1'b1 : shreg_nxt[0];
      // A new byte always wins over the end-of-last-frame flag.
      if (push_ok)                      tx_done <= 1'b0;
      else if (frame_end && fifo_empty) tx_done <= 1'b1;
    end
  end

  // Datapath registers; only meaningful while TRANSMITTING, so no reset.
  always_ff @(posedge clk) begin
    shreg    <= shreg_nxt;
    baud_cnt <= baud_nxt;
    bit_cnt  <= bit_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of single-byte frames, then burst, full-drop,
// same-edge re-trigger and mid-frame reset sequences. A line monitor pops
// expected frames from a scoreboard and checks every clock of each frame.
module tb_uart_tx;

  localparam int B  = 16;
  localparam int FB = 10 * B;

  logic       clk = 1'b0;
  logic       rst_n, trmt, TX, tx_done, full;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [9:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done),
    .full    (full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    trmt    = 1'b1;
    tx_data = d;
    tick();
    trmt    = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_done(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (tx_done === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Line monitor: on a start bit, check every clock of the expected frame.
  initial begin : monitor
    logic [9:0] f;
    int         bad_k;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        chk("frame_queued", 32'(sb.size() != 0), 1);
        if (sb.size() == 0) begin
          while (TX === 1'b0) @(negedge clk);
        end else begin
          f       = sb.pop_front();
          bad_k   = -1;
          aborted = 1'b0;
          for (int k = 0; k < FB; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (TX !== f[k / B] && bad_k < 0) bad_k = k;
          end
          if (!aborted) chk($sformatf("frame_%02h_first_bad_clk", f[8:1]), bad_k, -1);
        end
      end
    end
  end

  initial begin : main
    int t0, at, lows;
    rst_n   = 1'b0;
    trmt    = 1'b0;
    tx_data = 8'h00;
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h55, 10'h2AA};
    vecs[4] = '{8'hAA, 10'h354};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_TX", TX, 1);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_full", full, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_TX", TX, 1);

    // Single frames from the table
    foreach (vecs[i]) begin
      sb.push_back(vecs[i].frame);
      send(vecs[i].data);
      t0 = cyc;
      chk("accept_clears_done", tx_done, 0);
      chk("accept_full", full, 0);
      tick();
      chk("start_latency", TX, 0);
      wait_done(FB + 20, at);
      chk("done_time", at - t0, FB + 1);
      tick();
      chk("idle_after_frame", TX, 1);
    end

    // Burst of five on consecutive cycles, then drops while full
    for (int i = 1; i <= 5; i++) begin
      sb.push_back({1'b1, 8'(i), 1'b0});
      trmt    = 1'b1;
      tx_data = 8'(i);
      tick();
      if (i == 1) t0 = cyc;
      if (i == 4) chk("burst_full_after_4", full, 0);
    end
    chk("burst_full_after_5", full, 1);
    tx_data = 8'h77;
    tick();
    trmt = 1'b0;
    chk("drop_while_full", full, 1);
    repeat (FB - 5) tick();
    trmt    = 1'b1;
    tx_data = 8'h78;
    tick();                       // same edge as the first frame-end pop
    trmt = 1'b0;
    chk("drop_on_pop_edge", full, 0);
    wait_done(6 * FB, at);
    chk("burst_done_time", at - t0, 5 * FB + 1);
    chk("burst_sb_drained", sb.size(), 0);

    // trmt exactly on the stop-bit completion edge, queue empty
    sb.push_back({1'b1, 8'h3C, 1'b0});
    send(8'h3C);
    repeat (FB) tick();
    sb.push_back({1'b1, 8'hC3, 1'b0});
    trmt    = 1'b1;
    tx_data = 8'hC3;
    tick();
    trmt = 1'b0;
    t0   = cyc;
    chk("same_edge_done_held", tx_done, 0);
    chk("same_edge_TX_high", TX, 1);
    tick();
    chk("same_edge_next_start", TX, 0);
    wait_done(FB + 20, at);
    chk("same_edge_done_time", at - t0, FB + 1);

    // Reset in the middle of a frame with a second byte still queued
    sb.push_back({1'b1, 8'hA5, 1'b0});
    send(8'hA5);
    sb.push_back({1'b1, 8'h96, 1'b0});
    send(8'h96);
    repeat (5 * B + 3) tick();
    chk("pre_reset_TX_low", TX, 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_TX", TX, 1);
    chk("async_rst_done", tx_done, 0);
    chk("async_rst_full", full, 0);
    tick();
    tick();
    rst_n = 1'b1;
    lows  = 0;
    for (int i = 0; i < 2 * FB; i++) begin
      tick();
      if (TX !== 1'b1) lows++;
    end
    chk("post_reset_quiet", lows, 0);
    chk("post_reset_done", tx_done, 0);

    // Still usable after reset
    sb.push_back({1'b1, 8'h81, 1'b0});
    send(8'h81);
    t0 = cyc;
    wait_done(FB + 20, at);
    chk("post_reset_done_time", at - t0, FB + 1);
    chk("final_sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
